// File: rtl/tcp_bench_pkg.sv
// Shared constants and types for the TCP benchmark transmit engine and receive checker.
// Register indices, status field offsets and the engine state encoding live here.
package tcp_bench_pkg;

   localparam int WORD_BYTES = 64;
   localparam int DATA_W     = 512;
   localparam int KEEP_W     = 64;
   localparam int WPO_W      = 10;

   localparam int CTRL_START   = 0;
   localparam int CTRL_LENGTH  = 1;
   localparam int CTRL_OPS     = 2;
   localparam int CTRL_OFFSET  = 3;
   localparam int CTRL_SESSION = 4;

   localparam int STAT_ACTIVE  = 0;
   localparam int STAT_OPS     = 1;
   localparam int STAT_RETRIES = 2;
   localparam int STAT_WORDS   = 3;
   localparam int STAT_FLAGS   = 4;

   localparam int FLAG_DONE    = 0;
   localparam int FLAG_CFG_ERR = 1;

   localparam int STS_ERR_LO = 62;
   localparam int STS_ERR_HI = 63;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_META,
      ST_WAIT_STATUS,
      ST_SEND_DATA,
      ST_DONE
   } tcp_state_t;

   typedef struct packed {
      logic [15:0] length;
      logic [15:0] session;
   } tx_meta_t;

   // Partial trailing bytes are dropped: only whole 64-byte words are sent.
   function automatic logic [WPO_W-1:0] words_per_op(input logic [15:0] len);
      return WPO_W'(len >> $clog2(WORD_BYTES));
   endfunction

endpackage

// File: rtl/tcp_pattern_gen.sv
// Payload pattern source: word index counter plus the {op index, index+offset} word format.
// The index advances only on a data handshake, so the word holds steady while stalled.
module tcp_pattern_gen
   import tcp_bench_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr,
   input  logic              adv,
   input  logic              active,
   input  logic [WPO_W-1:0]  wpo,
   input  logic [31:0]       offset,
   input  logic [31:0]       op_idx,
   output logic [DATA_W-1:0] data,
   output logic [KEEP_W-1:0] keep,
   output logic              last
);

   logic [WPO_W-1:0] k_q;
   logic             at_end;

   assign at_end = (k_q == wpo - WPO_W'(1));

   always_ff @(posedge clk) begin
      if (!rstn || clr)
         k_q <= '0;
      else if (adv)
         k_q <= at_end ? '0 : k_q + WPO_W'(1);
   end

   always_comb begin
      data = '0;
      keep = '0;
      last = 1'b0;
      if (active) begin
         data[31:0]  = {{(32-WPO_W){1'b0}}, k_q} + offset;
         data[63:32] = op_idx;
         keep        = '1;
         last        = at_end;
      end
   end

endmodule

// File: rtl/tcp_send_engine.sv
// TCP benchmark transmit stage: issues N fixed-length sends on one session, each a metadata
// request, a status wait (re-issuing the request on reject), then a patterned payload stream.
module tcp_send_engine
   import tcp_bench_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   output logic                   m_axis_tx_metadata_valid,
   input  logic                   m_axis_tx_metadata_ready,
   output logic [31:0]            m_axis_tx_metadata_data,
   input  logic                   s_axis_tx_status_valid,
   output logic                   s_axis_tx_status_ready,
   input  logic [63:0]            s_axis_tx_status_data,
   output logic                   m_axis_tx_data_valid,
   input  logic                   m_axis_tx_data_ready,
   output logic [DATA_W-1:0]      m_axis_tx_data_data,
   output logic [KEEP_W-1:0]      m_axis_tx_data_keep,
   output logic                   m_axis_tx_data_last,
   input  logic [15:0][31:0]      control_reg,
   output logic [7:0][31:0]       status_reg
);

   tcp_state_t       state_q, state_d;
   logic [2:0]       start_pipe;
   logic             start_evt, accept;
   logic [WPO_W-1:0] c_wpo, w_wpo;
   logic [31:0]      c_ops, c_off, w_ops, w_off;
   logic [15:0]      c_sess, w_sess;
   logic [31:0]      active_q, ops_done_q, retries_q, words_q;
   logic             cfg_err_q, done;
   logic             meta_hs, sts_hs, data_hs, sts_err, pat_last;
   tx_meta_t         meta;
   logic             unused_ok;

   // Two sync flops, then a third to find the rising edge.
   always_ff @(posedge clk) begin
      if (!rstn) start_pipe <= '0;
      else       start_pipe <= {start_pipe[1:0], control_reg[CTRL_START][0]};
   end
   assign start_evt = start_pipe[1] & ~start_pipe[2];
   assign accept    = start_evt && (state_q == ST_IDLE || state_q == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         c_wpo  <= '0;
         c_ops  <= '0;
         c_off  <= '0;
         c_sess <= '0;
      end else begin
         c_wpo  <= words_per_op(control_reg[CTRL_LENGTH][15:0]);
         c_ops  <= control_reg[CTRL_OPS];
         c_off  <= control_reg[CTRL_OFFSET];
         c_sess <= control_reg[CTRL_SESSION][15:0];
      end
   end

   assign meta_hs  = m_axis_tx_metadata_valid & m_axis_tx_metadata_ready;
   assign sts_hs   = s_axis_tx_status_valid & s_axis_tx_status_ready;
   assign data_hs  = m_axis_tx_data_valid & m_axis_tx_data_ready;
   assign sts_err  = |s_axis_tx_status_data[STS_ERR_HI:STS_ERR_LO];

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE:
            if (accept) begin
               if (c_wpo == '0)      state_d = ST_IDLE;
               else if (c_ops == '0) state_d = ST_DONE;
               else                  state_d = ST_SEND_META;
            end
         ST_SEND_META:
            if (meta_hs) state_d = ST_WAIT_STATUS;
         ST_WAIT_STATUS:
            if (sts_hs) state_d = sts_err ? ST_SEND_META : ST_SEND_DATA;
         ST_SEND_DATA:
            if (data_hs && pat_last)
               state_d = (ops_done_q + 32'd1 == w_ops) ? ST_DONE : ST_SEND_META;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      m_axis_tx_metadata_valid = (state_q == ST_SEND_META);
      s_axis_tx_status_ready   = (state_q == ST_WAIT_STATUS);
      m_axis_tx_data_valid     = (state_q == ST_SEND_DATA);
      done                     = (state_q == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_wpo      <= '0;
         w_ops      <= '0;
         w_off      <= '0;
         w_sess     <= '0;
         active_q   <= '0;
         ops_done_q <= '0;
         retries_q  <= '0;
         words_q    <= '0;
         cfg_err_q  <= 1'b0;
      end else if (accept) begin
         w_wpo      <= c_wpo;
         w_ops      <= c_ops;
         w_off      <= c_off;
         w_sess     <= c_sess;
         active_q   <= '0;
         ops_done_q <= '0;
         retries_q  <= '0;
         words_q    <= '0;
         cfg_err_q  <= (c_wpo == '0);
      end else begin
         if (state_q != ST_IDLE && state_q != ST_DONE) active_q <= active_q + 32'd1;
         if (data_hs && pat_last)                       ops_done_q <= ops_done_q + 32'd1;
         if (sts_hs && sts_err)                         retries_q <= retries_q + 32'd1;
         if (data_hs)                                   words_q <= words_q + 32'd1;
      end
   end

   assign meta.length  = {w_wpo, 6'd0};
   assign meta.session = w_sess;
   assign m_axis_tx_metadata_data = meta;

   tcp_pattern_gen u_pat (
      .clk    (clk),
      .rstn   (rstn),
      .clr    (accept),
      .adv    (data_hs),
      .active (m_axis_tx_data_valid),
      .wpo    (w_wpo),
      .offset (w_off),
      .op_idx (ops_done_q),
      .data   (m_axis_tx_data_data),
      .keep   (m_axis_tx_data_keep),
      .last   (pat_last)
   );
   assign m_axis_tx_data_last = pat_last;

   always_comb begin
      status_reg               = '0;
      status_reg[STAT_ACTIVE]  = active_q;
      status_reg[STAT_OPS]     = ops_done_q;
      status_reg[STAT_RETRIES] = retries_q;
      status_reg[STAT_WORDS]   = words_q;
      status_reg[STAT_FLAGS][FLAG_DONE]    = done;
      status_reg[STAT_FLAGS][FLAG_CFG_ERR] = cfg_err_q;
   end

   // Session/length echo in the status word is deliberately not checked.
   assign unused_ok = ^{control_reg[15:5], control_reg[CTRL_START][31:1],
                        s_axis_tx_status_data[61:0]};

endmodule

// File: tb/tb_tcp_send_engine.sv
// Scoreboard bench for tcp_send_engine: expected metas/words queued per run, checked on handshakes.
module tb_tcp_send_engine;

   logic              clk = 1'b0;
   logic              rstn;
   logic              mvalid, mrdy;
   logic [31:0]       mdata;
   logic              svalid, srdy;
   logic [63:0]       sdata;
   logic              dvalid, drdy;
   logic [511:0]      ddata;
   logic [63:0]       dkeep;
   logic              dlast;
   logic [15:0][31:0] ctrl;
   logic [7:0][31:0]  stat;

   int n_chk = 0;
   int n_bad = 0;

   logic [31:0] exp_meta[$];
   logic [64:0] exp_word[$];
   logic [1:0]  err_plan[$];
   bit          rand_rdy = 0;
   bit          stall = 0;
   logic [63:0] stall_d;
   bit          pend_sts = 0;
   bit          accepted = 0;
   int          words_seen = 0;

   always #5 clk = ~clk;

   tcp_send_engine dut (
      .clk                      (clk),
      .rstn                     (rstn),
      .m_axis_tx_metadata_valid (mvalid),
      .m_axis_tx_metadata_ready (mrdy),
      .m_axis_tx_metadata_data  (mdata),
      .s_axis_tx_status_valid   (svalid),
      .s_axis_tx_status_ready   (srdy),
      .s_axis_tx_status_data    (sdata),
      .m_axis_tx_data_valid     (dvalid),
      .m_axis_tx_data_ready     (drdy),
      .m_axis_tx_data_data      (ddata),
      .m_axis_tx_data_keep      (dkeep),
      .m_axis_tx_data_last      (dlast),
      .control_reg              (ctrl),
      .status_reg               (stat)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Input driver and handshake monitor: drive at negedge, sample 1 ns later.
   initial begin
      logic [1:0]  e;
      logic [64:0] w;
      forever begin
         @(negedge clk);
         drdy   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         mrdy   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         e      = (err_plan.size() > 0) ? err_plan[0] : 2'd0;
         svalid = 1'b1;
         sdata  = {e, 30'd0, ctrl[1][15:0], ctrl[4][15:0]};
         #1;
         if (!rstn) begin
            stall = 0; pend_sts = 0; accepted = 0;
            continue;
         end
         if (stall) begin
            chk("stable_valid", 64'(dvalid), 64'd1);
            chk("stable_data", ddata[63:0], stall_d);
         end
         stall   = dvalid && !drdy;
         stall_d = ddata[63:0];
         if (mvalid && mrdy) begin
            chk("meta_order", 64'(pend_sts), 64'd0);
            if (exp_meta.size() == 0) chk("meta_unexp", 64'd1, 64'd0);
            else chk("meta", 64'(mdata), 64'(exp_meta.pop_front()));
            pend_sts = 1; accepted = 0;
         end
         if (svalid && srdy) begin
            chk("sts_when", 64'(pend_sts), 64'd1);
            if (err_plan.size() > 0) e = err_plan.pop_front();
            else e = 2'd0;
            pend_sts = 0;
            accepted = (e == 2'd0);
         end
         if (dvalid && drdy) begin
            words_seen++;
            chk("data_after_accept", 64'(accepted), 64'd1);
            if (exp_word.size() == 0) chk("word_unexp", 64'd1, 64'd0);
            else begin
               w = exp_word.pop_front();
               chk("word", ddata[63:0], w[63:0]);
               chk("last", 64'(dlast), 64'(w[64]));
               chk("keep", dkeep, {64{1'b1}});
               chk("upper_zero", 64'(|ddata[511:64]), 64'd0);
            end
         end
      end
   end

   task automatic run_case(input logic [31:0] len, input int ops, input logic [31:0] off,
                           input logic [15:0] sess, input bit rnd, input int n_err,
                           input string name);
      int   wpo;
      bit   got_done;
      wpo = int'(len[15:6]);
      for (int i = 0; i < n_err; i++) err_plan.push_back(2'd1);
      if (wpo != 0 && ops != 0) begin
         for (int i = 0; i < ops + n_err; i++) exp_meta.push_back({len[15:6], 6'd0, sess});
         for (int op = 0; op < ops; op++)
            for (int k = 0; k < wpo; k++)
               exp_word.push_back({(k == wpo - 1), 32'(op), off + 32'(k)});
      end
      rand_rdy = rnd;
      @(negedge clk);
      ctrl[1] = len; ctrl[2] = 32'(ops); ctrl[3] = off; ctrl[4] = {16'd0, sess};
      repeat (2) @(negedge clk);
      ctrl[0] = 32'd1;
      repeat (4) @(negedge clk);
      ctrl[0] = 32'd0;
      got_done = 0;
      for (int i = 0; i < 3000 && !got_done; i++) begin
         @(negedge clk);
         #2;
         if (stat[4][0] || (wpo == 0 && i > 20)) got_done = 1;
      end
      chk({name, "_finished"}, 64'(got_done), 64'd1);
      repeat (4) @(negedge clk);
      #2;
      chk({name, "_meta_left"}, 64'(exp_meta.size()), 64'd0);
      chk({name, "_word_left"}, 64'(exp_word.size()), 64'd0);
      chk({name, "_ops_done"}, 64'(stat[1]), 64'((wpo == 0) ? 0 : ops));
      chk({name, "_retries"}, 64'(stat[2]), 64'((wpo == 0 || ops == 0) ? 0 : n_err));
      chk({name, "_words"}, 64'(stat[3]), 64'(ops * wpo));
      chk({name, "_flags"}, 64'(stat[4]), (wpo == 0) ? 64'd2 : 64'd1);
      if (wpo != 0 && ops != 0) chk({name, "_active_nz"}, 64'(stat[0] != 0), 64'd1);
      else chk({name, "_active_zero"}, 64'(stat[0]), 64'd0);
      rand_rdy = 0;
   endtask

   initial begin
      rstn = 1'b0;
      ctrl = '0;
      drdy = 1'b1; mrdy = 1'b1; svalid = 1'b0; sdata = '0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_meta_valid", 64'(mvalid), 64'd0);
      chk("rst_data_valid", 64'(dvalid), 64'd0);
      chk("rst_sts_ready", 64'(srdy), 64'd0);
      chk("rst_last", 64'(dlast), 64'd0);
      chk("rst_data", ddata[63:0], 64'd0);
      for (int i = 0; i < 8; i++) chk("rst_status", 64'(stat[i]), 64'd0);
      rstn = 1'b1;

      run_case(32'd256, 3, 32'h10, 16'd5, 0, 0, "basic");
      run_case(32'd256, 3, 32'h10, 16'd5, 1, 0, "rand_ready");
      run_case(32'd256, 2, 32'h100, 16'd9, 0, 1, "retry");
      run_case(32'd63, 3, 32'h0, 16'd5, 0, 0, "cfg_err");
      run_case(32'd256, 0, 32'h0, 16'd5, 0, 0, "zero_ops");
      run_case(32'd256, 1, 32'hFFFF_FFFE, 16'd7, 0, 0, "wrap");
      run_case(32'd200, 2, 32'h5, 16'd3, 1, 0, "odd_len");

      // Reset in the middle of the payload stream.
      for (int op = 0; op < 3; op++) begin
         exp_meta.push_back(32'h0100_0005);
         for (int k = 0; k < 4; k++) exp_word.push_back({(k == 3), 32'(op), 32'h10 + 32'(k)});
      end
      ctrl[1] = 32'd256; ctrl[2] = 32'd3; ctrl[3] = 32'h10; ctrl[4] = 32'd5;
      repeat (2) @(negedge clk);
      ctrl[0] = 32'd1;
      repeat (4) @(negedge clk);
      ctrl[0] = 32'd0;
      words_seen = 0;
      for (int i = 0; i < 500 && words_seen < 5; i++) @(negedge clk);
      chk("mid_reached", 64'(words_seen >= 5), 64'd1);
      rstn = 1'b0;
      @(negedge clk);
      #2;
      chk("mid_meta_valid", 64'(mvalid), 64'd0);
      chk("mid_data_valid", 64'(dvalid), 64'd0);
      chk("mid_last", 64'(dlast), 64'd0);
      for (int i = 0; i < 8; i++) chk("mid_status", 64'(stat[i]), 64'd0);
      exp_meta.delete(); exp_word.delete(); err_plan.delete();
      @(negedge clk);
      rstn = 1'b1;
      run_case(32'd256, 3, 32'h10, 16'd5, 0, 0, "after_rst");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
